// File: rtl/vga_sync_gen_pkg.sv
// ----------------------------------------------------------------------------
// vga_sync_gen_pkg
//   Shared VGA raster timing for the sync generator and the pixel generator.
//   It holds the 640x480@60 timing constants, the derived totals and
//   sync-window bounds, and a small window-compare helper.
//   The pixel generator imports this same package, so both blocks agree on
//   the geometry.
// ----------------------------------------------------------------------------
package vga_sync_gen_pkg;

    // Counter and key-code widths. 10 bits covers H_TOTAL-1 = 799 with headroom.
    localparam int CNT_W = 10;
    localparam int ARB_W = 6;

    // Default pixel clock divider: 100 MHz system clock / 4 = 25 MHz.
    localparam int DEF_CLK_DIV = 4;

    // Horizontal timing, in pixels.
    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800

    // Vertical timing, in lines.
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525

    // Sync windows are half-open: [START, END).
    localparam int DEF_HS_START = DEF_H_VIS + DEF_H_FP;               // 656
    localparam int DEF_HS_END   = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC;  // 752
    localparam int DEF_VS_START = DEF_V_VIS + DEF_V_FP;               // 490
    localparam int DEF_VS_END   = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC;  // 492

    // Unsigned half-open window test: lo <= x < hi.
    function automatic logic in_window(
        input logic [CNT_W-1:0] x,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_pix_tick.sv
// ----------------------------------------------------------------------------
// pix_tick_gen
//   Pixel-rate divider. It counts 0..CLK_DIV-1 on the system clock.
//   Ports:
//     clk       in   system clock
//     rst_n     in   asynchronous reset, active-low
//     tick_en   out  combinational; high in the cycle where the divider
//                    sits at its terminal count. The owner advances its
//                    state on that edge.
//     pix_tick  out  registered; high for one clk after each terminal count,
//                    so it rises on the same edge as the advanced counters.
//   With CLK_DIV = 1 the divider stays at 0 and tick_en is always high,
//   which gives a tick every cycle.
// ----------------------------------------------------------------------------
module pix_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_en,
    output logic pix_tick
);

    // Keep at least one bit so CLK_DIV = 1 still elaborates cleanly.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick_en = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            pix_tick <= 1'b0;
        end else begin
            pix_tick <= tick_en;
            div_cnt  <= tick_en ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// ----------------------------------------------------------------------------
// vga_sync_gen
//   VGA raster timing generator. It produces the pixel/line counters, the
//   active-video flag and active-low syncs, plus line and frame strobes. It
//   also latches the key code once per frame so the pixel generator never
//   sees it change mid-frame.
//   Ports:
//     clk          in   system clock
//     rst_n        in   asynchronous reset, active-low
//     arbiter_in   in   raw key code from the keyboard logic
//     arbiter      out  key code latched on the frame_start edge
//     h_cnt        out  horizontal position, 0..H_TOTAL-1
//     v_cnt        out  vertical line, 0..V_TOTAL-1
//     vga_valid    out  high while h_cnt < H_VIS and v_cnt < V_VIS
//     hsync        out  active-low horizontal sync
//     vsync        out  active-low vertical sync
//     pix_tick     out  one-clk pulse per pixel
//     line_start   out  one-clk pulse when h_cnt wraps to 0
//     frame_start  out  one-clk pulse when (h_cnt, v_cnt) becomes (0, 0)
//   Reset parks the counters at the last pixel of a frame. The first tick
//   after release therefore wraps to (0,0) and opens a full frame.
// ----------------------------------------------------------------------------
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int H_VIS   = DEF_H_VIS,
    parameter int H_FP    = DEF_H_FP,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int V_VIS   = DEF_V_VIS,
    parameter int V_FP    = DEF_V_FP,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BP    = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ARB_W-1:0] arbiter_in,
    output logic [ARB_W-1:0] arbiter,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             vga_valid,
    output logic             hsync,
    output logic             vsync,
    output logic             pix_tick,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // Pixel-rate divider
    // ------------------------------------------------------------------
    logic tick_en;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_en  (tick_en),
        .pix_tick (pix_tick)
    );

    // ------------------------------------------------------------------
    // Next raster position. The decoded outputs are computed from these
    // values rather than from the current counters. That way the syncs,
    // valid flag and strobes register on the same edge as h_cnt/v_cnt,
    // with no one-pixel lag.
    // ------------------------------------------------------------------
    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
        v_nxt  = v_cnt;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Raster state, decoded outputs and per-frame key latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            vga_valid   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            arbiter     <= '0;
        end else if (tick_en) begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            hsync       <= ~in_window(h_nxt, HS_START, HS_END);
            vsync       <= ~in_window(v_nxt, VS_START, VS_END);
            vga_valid   <= (h_nxt < H_VIS_C) && (v_nxt < V_VIS_C);
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
            // Sample the key only as a new frame opens, so a frame is never torn.
            if (h_wrap && v_wrap) begin
                arbiter <= arbiter_in;
            end
        end else begin
            // Levels hold between ticks; only the strobes fall.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
